// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM microphone receiver.
// Counts are kept at full width and only clipped when a sample is produced.
package pdm_pkg;

  localparam int DEF_CLK_DIV = 25;
  localparam int DEF_DECIM   = 256;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_STEREO  = 0;
  localparam int DEF_MIC_SEL = 0;

  // Width needed to hold a ones-count of 0..decim inclusive.
  function automatic int count_width(input int decim);
    return $clog2(decim + 1);
  endfunction

  function automatic int unsigned sat_clip(input int unsigned ones, input int out_w);
    int unsigned lim;
    lim = (out_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << out_w) - 32'd1);
    return (ones > lim) ? lim : ones;
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone bit-clock divider: produces mclk and one-cycle rise/fall strobes
// marking the cycles in which mclk toggles. Held at zero while en is low.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mclk,
  output logic rise,
  output logic fall
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = en && (div_cnt == DIV_LAST);
  assign rise = wrap && !mclk;
  assign fall = wrap && mclk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      mclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      mclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      mclk    <= ~mclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: ones-count decimation per channel with a valid/ready
// sample register and sticky overrun. Define PDM_MIC_RX_SYNC_EN to add a 2-flop micData synchroniser.
module pdm_mic_rx
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DECIM   = DEF_DECIM,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int STEREO  = DEF_STEREO,
  parameter int MIC_SEL = DEF_MIC_SEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             mclk,
  output logic             micLRSel,
  input  logic             micData,
  output logic [OUT_W-1:0] sample_l,
  output logic [OUT_W-1:0] sample_r,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int AW = count_width(DECIM);
  localparam int BW = $clog2(DECIM);
  localparam logic [BW-1:0] BIT_LAST = BW'(DECIM - 1);
  localparam bit IS_STEREO = (STEREO != 0);

  logic             rise;
  logic             fall;
  logic             cap_bit;
  logic [AW-1:0]    acc_l;
  logic [AW-1:0]    acc_r;
  logic [AW-1:0]    ones_l;
  logic [AW-1:0]    ones_r;
  logic [BW-1:0]    bit_cnt;
  logic             close_pend;
  logic             last_bit;
  logic             win_close;
  logic             load;
  logic             drop;
  logic [OUT_W-1:0] new_l;
  logic [OUT_W-1:0] new_r;

  assign micLRSel = (MIC_SEL != 0);

  pdm_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .mclk (mclk),
    .rise (rise),
    .fall (fall)
  );

`ifdef PDM_MIC_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], micData};
    end
  end

  assign cap_bit = sync_q[1];
`else
  assign cap_bit = micData;
`endif

  // The closing bit belongs to the closing window, so the result includes it.
  assign last_bit  = (bit_cnt == BIT_LAST);
  assign win_close = IS_STEREO ? (fall && close_pend) : (rise && last_bit);
  assign ones_l    = IS_STEREO ? acc_l : (acc_l + AW'(cap_bit));
  assign ones_r    = IS_STEREO ? (acc_r + AW'(cap_bit)) : '0;
  assign new_l     = OUT_W'(sat_clip(32'(ones_l), OUT_W));
  assign new_r     = OUT_W'(sat_clip(32'(ones_r), OUT_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_l      <= '0;
      acc_r      <= '0;
      bit_cnt    <= '0;
      close_pend <= 1'b0;
    end else if (!en) begin
      acc_l      <= '0;
      acc_r      <= '0;
      bit_cnt    <= '0;
      close_pend <= 1'b0;
    end else begin
      if (rise) begin
        bit_cnt <= last_bit ? '0 : (bit_cnt + BW'(1));
        if (last_bit && !IS_STEREO) begin
          acc_l <= '0;
        end else begin
          acc_l <= acc_l + AW'(cap_bit);
        end
        if (last_bit && IS_STEREO) begin
          close_pend <= 1'b1;
        end
      end
      // In stereo the window ends on the right capture after the last left bit.
      if (fall && IS_STEREO) begin
        if (close_pend) begin
          acc_l      <= '0;
          acc_r      <= '0;
          close_pend <= 1'b0;
        end else begin
          acc_r <= acc_r + AW'(cap_bit);
        end
      end
    end
  end

  assign load = win_close && (!valid || ready);
  assign drop = win_close && valid && !ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_l <= '0;
      sample_r <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (load) begin
        sample_l <= new_l;
        sample_r <= new_r;
        valid    <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Self-checking bench for pdm_mic_rx: three instances (fast mono, long mono,
// stereo) driven with directed and random PDM streams against a counting model.
module tb_pdm_mic_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] en;
  logic [2:0] dat;
  logic [2:0] rdy;
  logic [2:0] clr;
  logic [2:0] mclk_o;
  logic [2:0] lrsel_o;
  logic [2:0] valid_o;
  logic [2:0] ovr_o;
  logic [7:0] sl [3];
  logic [7:0] sr [3];

  int checks = 0;
  int errors = 0;

  // Held-sample model for the stereo instance.
  int   mL, mR;
  logic mV, mO;
  logic nextL;

  always #5 clk = ~clk;

  pdm_mic_rx #(.CLK_DIV(2), .DECIM(16), .OUT_W(8), .STEREO(0), .MIC_SEL(0)) u_a (
    .clk(clk), .reset(reset), .en(en[0]), .mclk(mclk_o[0]), .micLRSel(lrsel_o[0]),
    .micData(dat[0]), .sample_l(sl[0]), .sample_r(sr[0]), .valid(valid_o[0]),
    .ready(rdy[0]), .overrun(ovr_o[0]), .clr_overrun(clr[0]));

  pdm_mic_rx #(.CLK_DIV(4), .DECIM(256), .OUT_W(8), .STEREO(0), .MIC_SEL(0)) u_b (
    .clk(clk), .reset(reset), .en(en[1]), .mclk(mclk_o[1]), .micLRSel(lrsel_o[1]),
    .micData(dat[1]), .sample_l(sl[1]), .sample_r(sr[1]), .valid(valid_o[1]),
    .ready(rdy[1]), .overrun(ovr_o[1]), .clr_overrun(clr[1]));

  pdm_mic_rx #(.CLK_DIV(4), .DECIM(16), .OUT_W(8), .STEREO(1), .MIC_SEL(1)) u_c (
    .clk(clk), .reset(reset), .en(en[2]), .mclk(mclk_o[2]), .micLRSel(lrsel_o[2]),
    .micData(dat[2]), .sample_l(sl[2]), .sample_r(sr[2]), .valid(valid_o[2]),
    .ready(rdy[2]), .overrun(ovr_o[2]), .clr_overrun(clr[2]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat8(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // 0 zeros, 1 ones, 3 alternating starting with 1, otherwise random
  function automatic logic genBit(input int pat, input int idx);
    case (pat)
      0:       return 1'b0;
      1:       return 1'b1;
      3:       return (idx % 2) == 0;
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic waitMclk(input int k, input logic level);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mclk_o[k] !== level && n < 64);
    if (mclk_o[k] !== level) checkOutput("mclk_wait", 32'(mclk_o[k]), 32'(level));
  endtask

  task automatic applyMonoStimulus(input int pat, output int ones);
    logic b;
    ones = 0;
    b = genBit(pat, 0);
    dat[1] = b;
    en[1] = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ones += b ? 1 : 0;
      waitMclk(1, 1'b1);
      @(negedge clk);
      b = genBit(pat, i + 1);
      dat[1] = b;
      if (i != 255) waitMclk(1, 1'b0);
    end
  endtask

  // Left bit changes mid low half, right bit mid high half; closeRdy/closeClr
  // are held only across the window-closing fall edge.
  task automatic applyStimulus(input int patL, input int patR, input logic closeRdy,
                               input logic closeClr, output int onesL, output int onesR);
    logic b;
    onesL = 0;
    onesR = 0;
    if (!en[2]) begin
      nextL = genBit(patL, 0);
      dat[2] = nextL;
      en[2] = 1'b1;
    end
    for (int i = 0; i < 16; i++) begin
      onesL += nextL ? 1 : 0;
      waitMclk(2, 1'b1);
      @(negedge clk);
      b = genBit(patR, i);
      dat[2] = b;
      onesR += b ? 1 : 0;
      if (i == 15) begin
        @(negedge clk);
        @(negedge clk);
        rdy[2] = closeRdy;
        clr[2] = closeClr;
      end
      waitMclk(2, 1'b0);
      rdy[2] = 1'b0;
      clr[2] = 1'b0;
      @(negedge clk);
      nextL = (i == 15) ? genBit(2, 0) : genBit(patL, i + 1);
      dat[2] = nextL;
    end
  endtask

  task automatic modelClose(input int ol, input int orr, input logic r, input logic c);
    if (!mV || r) begin
      mL = sat8(ol);
      mR = sat8(orr);
      mV = 1'b1;
      if (c) mO = 1'b0;
    end else begin
      mO = 1'b1;
    end
  endtask

  task automatic checkStereo(input string tag);
    checkOutput({tag, ".valid"}, 32'(valid_o[2]), 32'(mV));
    checkOutput({tag, ".sample_l"}, 32'(sl[2]), 32'(mL));
    checkOutput({tag, ".sample_r"}, 32'(sr[2]), 32'(mR));
    checkOutput({tag, ".overrun"}, 32'(ovr_o[2]), 32'(mO));
  endtask

  task automatic pulseClr();
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    mO = 1'b0;
  endtask

  task automatic pulseReady();
    rdy[2] = 1'b1;
    @(negedge clk);
    rdy[2] = 1'b0;
    mV = 1'b0;
  endtask

  initial begin
    int n, m, ol, orr;
    int pats [4] = '{1, 0, 3, 2};
    reset = 1'b1;
    en = '0; dat = '0; rdy = '0; clr = '0;
    mL = 0; mR = 0; mV = 1'b0; mO = 1'b0; nextL = 1'b0;
    dat[0] = 1'b1;
    repeat (3) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      checkOutput("rst.mclk", 32'(mclk_o[k]), 0);
      checkOutput("rst.valid", 32'(valid_o[k]), 0);
      checkOutput("rst.overrun", 32'(ovr_o[k]), 0);
      checkOutput("rst.sample_l", 32'(sl[k]), 0);
      checkOutput("rst.sample_r", 32'(sr[k]), 0);
    end
    checkOutput("rst.lrsel_a", 32'(lrsel_o[0]), 0);
    checkOutput("rst.lrsel_c", 32'(lrsel_o[2]), 1);
    reset = 1'b0;
    @(negedge clk);

    // Fast mono: first rise CLK_DIV after en, window ends 15 mclk periods later.
    rdy[0] = 1'b1;
    en[0] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o[0] && n < 300);
    checkOutput("a.first_valid", n, 2 + 15 * 4);
    checkOutput("a.sample_l", 32'(sl[0]), 16);
    checkOutput("a.sample_r", 32'(sr[0]), 0);
    m = 0;
    do begin
      @(negedge clk);
      m++;
      if (m == 1) checkOutput("a.valid_pulse", 32'(valid_o[0]), 0);
    end while (!valid_o[0] && m < 300);
    checkOutput("a.period", m, 64);
    checkOutput("a.sample_l2", 32'(sl[0]), 16);
    en[0] = 1'b0;

    // Long mono windows: saturation, zeros, alternating, random.
    for (int p = 0; p < 4; p++) begin
      applyMonoStimulus(pats[p], ol);
      checkOutput("b.valid", 32'(valid_o[1]), 1);
      checkOutput("b.sample_l", 32'(sl[1]), 32'(sat8(ol)));
      checkOutput("b.sample_r", 32'(sr[1]), 0);
      en[1] = 1'b0;
      rdy[1] = 1'b1;
      @(negedge clk);
      rdy[1] = 1'b0;
      checkOutput("b.valid_clear", 32'(valid_o[1]), 0);
    end

    // Stereo: left high at rises, right low at falls.
    applyStimulus(1, 0, 1'b0, 1'b0, ol, orr);
    modelClose(ol, orr, 1'b0, 1'b0);
    checkStereo("c.w1");
    applyStimulus(2, 2, 1'b0, 1'b0, ol, orr);
    modelClose(ol, orr, 1'b0, 1'b0);
    checkStereo("c.w2_drop");
    en[2] = 1'b0;
    pulseClr();
    checkStereo("c.clr");
    pulseReady();
    checkStereo("c.accept");

    applyStimulus(2, 2, 1'b0, 1'b0, ol, orr);
    modelClose(ol, orr, 1'b0, 1'b0);
    checkStereo("c.w3");
    applyStimulus(2, 2, 1'b1, 1'b0, ol, orr);
    modelClose(ol, orr, 1'b1, 1'b0);
    checkStereo("c.w4_accept_close");
    applyStimulus(2, 2, 1'b0, 1'b1, ol, orr);
    modelClose(ol, orr, 1'b0, 1'b1);
    checkStereo("c.w5_drop_clr");

    // en dropped mid-window: partial ones must not leak into the next sample.
    dat[2] = 1'b1;
    repeat (50) @(negedge clk);
    en[2] = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("c.en_off.mclk", 32'(mclk_o[2]), 0);
    checkStereo("c.en_off");
    pulseClr();
    pulseReady();
    applyStimulus(2, 2, 1'b0, 1'b0, ol, orr);
    modelClose(ol, orr, 1'b0, 1'b0);
    checkStereo("c.w6_restart");

    // Reset mid-window clears outputs asynchronously.
    dat[2] = 1'b1;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    en[2] = 1'b0;
    #1;
    mL = 0; mR = 0; mV = 1'b0; mO = 1'b0;
    checkOutput("c.async_rst.mclk", 32'(mclk_o[2]), 0);
    checkStereo("c.async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    applyStimulus(2, 2, 1'b0, 1'b0, ol, orr);
    modelClose(ol, orr, 1'b0, 1'b0);
    checkStereo("c.w7_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
